core_lsu_wbuf: RTL and testbench

In-order store buffer between LSU M2 and the DRAM manager / uncached bus. It accepts M2 write requests (`we_valid`/`we_ready`) and holds up to DEPTH stores. Cached hits drain to the data-RAM write port; uncached stores drain as single bus write transactions. It reports `pending_write` and supports an address-hazard check for early loads, plus a drain barrier for cacop and uncached reads.

---
 rtl/core_lsu_wbuf_pkg.sv | 18 +
 rtl/core_lsu_wbuf_fifo.sv | 49 ++++
 rtl/core_lsu_wbuf.sv | 97 +++++++++
 tb/tb_core_lsu_wbuf.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_wbuf_pkg.sv
// core_lsu_wbuf_pkg: store-buffer entry type, way-count default and one-hot drain FSM states
package core_lsu_wbuf_pkg;
  localparam int DWAY_CNT = 4;
  typedef struct packed {
    logic                uncached;
    logic [31:0]         paddr;
    logic [31:0]         wdata;
    logic [3:0]          strobe;
    logic [1:0]          size;
    logic [DWAY_CNT-1:0] sel;
  } wbuf_entry_t;
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CWR   = 4'b0010,
    S_UREQ  = 4'b0100,
    S_URESP = 4'b1000
  } wbuf_state_t;
endpackage

// File: rtl/core_lsu_wbuf_fifo.sv
// core_lsu_wbuf_fifo: circular entry FIFO; push_i/din_i in, pop_i, full_o/empty_o, head_o, mem_o + vld_o for hazard compare
module core_lsu_wbuf_fifo
  import core_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wbuf_entry_t      din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output wbuf_entry_t      head_o,
  output wbuf_entry_t      mem_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[head_q];
  assign mem_o   = mem_q;
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] off;
    assign off      = PW'(i) - head_q;
    assign vld_o[i] = {1'b0, off} < cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= din_i;
        tail_q        <= tail_q + PW'(1);
      end
      if (do_pop) head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/core_lsu_wbuf.sv
// core_lsu_wbuf: in-order store buffer; ports we_* (M2 in), ram_* (cached drain), bus_* (uncached drain), chk_* (load hazard), drain_* (barrier), pending_write_o
module core_lsu_wbuf
  import core_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WAY_CNT = DWAY_CNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_valid_i,
  output logic               we_ready_o,
  input  logic               uncached_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         strobe_i,
  input  logic [1:0]         size_i,
  input  logic [WAY_CNT-1:0] we_sel_i,
  output logic               ram_we_o,
  input  logic               ram_ready_i,
  output logic [31:0]        ram_addr_o,
  output logic [31:0]        ram_wdata_o,
  output logic [3:0]         ram_strobe_o,
  output logic [WAY_CNT-1:0] ram_sel_o,
  output logic               bus_awvalid_o,
  input  logic               bus_awready_i,
  output logic [31:0]        bus_addr_o,
  output logic [31:0]        bus_wdata_o,
  output logic [3:0]         bus_strobe_o,
  output logic [1:0]         bus_size_o,
  input  logic               bus_bvalid_i,
  output logic               pending_write_o,
  input  logic [31:0]        chk_paddr_i,
  output logic               chk_hit_o,
  input  logic               drain_req_i,
  output logic               drain_done_o
);
  wbuf_state_t      state_q, state_d;
  wbuf_entry_t      din, head;
  wbuf_entry_t      mem [DEPTH];
  logic [DEPTH-1:0] vld, hit;
  logic             full, empty, push, pop, nxt_vld, nxt_unc;
  logic             ram_we_q, awvalid_q, uresp_q;
  logic             chk_unused;
  assign din = '{uncached: uncached_i, paddr: paddr_i, wdata: wdata_i, strobe: strobe_i, size: size_i, sel: we_sel_i};
  core_lsu_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (din),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head),
    .mem_o  (mem),
    .vld_o  (vld)
  );
  assign we_ready_o = !full;
  assign push       = we_valid_i && !full;
  assign pop        = (state_q == S_CWR && ram_ready_i) || (state_q == S_UREQ && bus_awready_i);
  assign nxt_vld    = !empty || push;
  assign nxt_unc    = empty ? uncached_i : head.uncached;
  always_comb
    state_d = state_q == S_IDLE ? (nxt_vld ? (nxt_unc ? S_UREQ : S_CWR) : S_IDLE) :
              state_q == S_CWR  ? (ram_ready_i ? S_IDLE : S_CWR) :
              state_q == S_UREQ ? (bus_awready_i ? S_URESP : S_UREQ) :
              bus_bvalid_i ? S_IDLE : S_URESP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ram_we_q  <= 1'b0;
      awvalid_q <= 1'b0;
      uresp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_we_q  <= state_d == S_CWR;
      awvalid_q <= state_d == S_UREQ;
      uresp_q   <= state_d == S_URESP;
    end
  end
  assign ram_we_o        = ram_we_q;
  assign ram_addr_o      = head.paddr;
  assign ram_wdata_o     = head.wdata;
  assign ram_strobe_o    = head.strobe;
  assign ram_sel_o       = head.sel;
  assign bus_awvalid_o   = awvalid_q;
  assign bus_addr_o      = head.paddr;
  assign bus_wdata_o     = head.wdata;
  assign bus_strobe_o    = head.strobe;
  assign bus_size_o      = head.size;
  assign pending_write_o = !empty || uresp_q;
  assign drain_done_o    = drain_req_i && !pending_write_o;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld[i] && mem[i].paddr[31:2] == chk_paddr_i[31:2];
  end
  assign chk_hit_o  = |hit;
  assign chk_unused = ^chk_paddr_i[1:0];
endmodule

// File: tb/tb_core_lsu_wbuf.sv
// tb_core_lsu_wbuf: scoreboard bench for core_lsu_wbuf with directed and random stimulus
module tb_core_lsu_wbuf;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic we_valid_i = 0, we_ready_o, uncached_i = 0;
  logic [31:0] paddr_i = 0, wdata_i = 0, chk_paddr_i = 0;
  logic [3:0] strobe_i = 0, we_sel_i = 0;
  logic [1:0] size_i = 0;
  logic ram_we_o, ram_ready_i = 0;
  logic [31:0] ram_addr_o, ram_wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0] ram_strobe_o, ram_sel_o, bus_strobe_o;
  logic [1:0] bus_size_o;
  logic bus_awvalid_o, bus_awready_i = 0, bus_bvalid_i = 0;
  logic pending_write_o, chk_hit_o, drain_req_i = 0, drain_done_o;
  core_lsu_wbuf #(.DEPTH(DEPTH), .WAY_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .we_valid_i(we_valid_i), .we_ready_o(we_ready_o),
    .uncached_i(uncached_i), .paddr_i(paddr_i), .wdata_i(wdata_i), .strobe_i(strobe_i),
    .size_i(size_i), .we_sel_i(we_sel_i), .ram_we_o(ram_we_o), .ram_ready_i(ram_ready_i),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_strobe_o(ram_strobe_o),
    .ram_sel_o(ram_sel_o), .bus_awvalid_o(bus_awvalid_o), .bus_awready_i(bus_awready_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_strobe_o(bus_strobe_o),
    .bus_size_o(bus_size_o), .bus_bvalid_i(bus_bvalid_i), .pending_write_o(pending_write_o),
    .chk_paddr_i(chk_paddr_i), .chk_hit_o(chk_hit_o), .drain_req_i(drain_req_i),
    .drain_done_o(drain_done_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          unc;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  z;
    logic [3:0]  sel;
  } ent_t;
  ent_t q[$];
  bit outst = 0;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      outst = 0;
    end else begin
      bit hit, pend, rdy;
      ent_t e;
      hit = 0;
      foreach (q[i]) if (q[i].a[31:2] == chk_paddr_i[31:2]) hit = 1;
      pend = q.size() != 0 || outst;
      rdy = q.size() < DEPTH;
      e = we_valid_i ? '{uncached_i, paddr_i, wdata_i, strobe_i, size_i, we_sel_i} : '{0, 0, 0, 0, 0, 0};
      chk("we_ready", we_ready_o, rdy);
      chk("pending", pending_write_o, pend);
      chk("chk_hit", chk_hit_o, hit);
      chk("drain_done", drain_done_o, drain_req_i && !pend);
      if (ram_we_o) begin
        if (q.size() == 0 || q[0].unc || outst) chk("ram_we_out_of_order", ram_we_o, 0);
        else begin
          chk("ram_payload", {ram_addr_o, ram_wdata_o, ram_strobe_o, ram_sel_o}, {q[0].a, q[0].d, q[0].s, q[0].sel});
          if (ram_ready_i) void'(q.pop_front());
        end
      end
      if (outst && bus_bvalid_i) outst = 0;
      if (bus_awvalid_o) begin
        if (q.size() == 0 || !q[0].unc || outst) chk("awvalid_out_of_order", bus_awvalid_o, 0);
        else begin
          chk("bus_payload", {bus_addr_o, bus_wdata_o, bus_strobe_o, bus_size_o}, {q[0].a, q[0].d, q[0].s, q[0].z});
          if (bus_awready_i) begin
            void'(q.pop_front());
            outst = 1;
          end
        end
      end
      if (we_valid_i && rdy) q.push_back(e);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input bit u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] z);
    int n;
    n = 0;
    we_valid_i = 1; uncached_i = u; paddr_i = a; wdata_i = d; strobe_i = s; size_i = z;
    we_sel_i = 4'b1 << $urandom_range(0, 3);
    while (!we_ready_o && n < 64) begin
      tick();
      n++;
    end
    chk("store_accept", we_ready_o, 1);
    tick();
    we_valid_i = 0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (pending_write_o && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", pending_write_o, 0);
  endtask
  task automatic reset_vals(input string n);
    chk(n, {ram_we_o, bus_awvalid_o, pending_write_o, chk_hit_o, drain_done_o, we_ready_o}, 6'b000001);
  endtask
  initial begin
    int n;
    tick(); tick();
    reset_vals("reset_values");
    rst_n = 1;
    tick();
    ram_ready_i = 1;
    store(0, 32'h100, 32'hDEADBEEF, 4'hF, 2'd2);
    chk("lat_ram_we", ram_we_o, 1);
    chk("lat_payload", {ram_addr_o, ram_wdata_o, ram_strobe_o}, {32'h100, 32'hDEADBEEF, 4'hF});
    chk("lat_pend_hi", pending_write_o, 1);
    tick();
    chk("lat_pend_lo", pending_write_o, 0);
    chk("lat_ram_we_lo", ram_we_o, 0);
    ram_ready_i = 0;
    for (int i = 1; i <= 4; i++) store(0, 32'h400 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'(i), 2'd0);
    chk("full_not_ready", we_ready_o, 0);
    ram_ready_i = 1;
    store(0, 32'h414, 32'h1111_0005, 4'h5, 2'd0);
    wait_idle();
    ram_ready_i = 0;
    store(1, 32'hBFD0_0000, 32'hCAFE_F00D, 4'hF, 2'd2);
    for (int i = 0; i < 3; i++) begin
      chk("aw_hold", {bus_awvalid_o, bus_addr_o, bus_wdata_o, bus_size_o}, {1'b1, 32'hBFD0_0000, 32'hCAFE_F00D, 2'd2});
      tick();
    end
    bus_awready_i = 1;
    tick();
    bus_awready_i = 0;
    chk("aw_drop", bus_awvalid_o, 0);
    tick(); tick();
    chk("uresp_pend", pending_write_o, 1);
    bus_bvalid_i = 1;
    tick();
    bus_bvalid_i = 0;
    chk("uresp_done", pending_write_o, 0);
    ram_ready_i = 1; bus_awready_i = 1;
    store(1, 32'hBFD0_0010, 32'h0000_00AA, 4'h1, 2'd0);
    store(0, 32'h300, 32'h3333_3333, 4'hF, 2'd2);
    for (int i = 0; i < 6; i++) begin
      chk("order_no_ram", ram_we_o, 0);
      tick();
    end
    bus_bvalid_i = 1;
    tick();
    bus_bvalid_i = 0;
    n = 0;
    while (!ram_we_o && n < 10) begin
      tick();
      n++;
    end
    chk("order_ram_after", ram_we_o, 1);
    wait_idle();
    ram_ready_i = 0;
    store(0, 32'h204, 32'h2222_2222, 4'h3, 2'd1);
    chk_paddr_i = 32'h206;
    #1 chk("hazard_hit", chk_hit_o, 1);
    chk_paddr_i = 32'h208;
    #1 chk("hazard_miss", chk_hit_o, 0);
    ram_ready_i = 1;
    wait_idle();
    ram_ready_i = 0;
    store(0, 32'h500, 32'h5, 4'hF, 2'd2);
    store(0, 32'h504, 32'h6, 4'hF, 2'd2);
    drain_req_i = 1;
    chk("drain_wait", drain_done_o, 0);
    ram_ready_i = 1;
    n = 0;
    while (pending_write_o && n < 20) begin
      tick();
      n++;
    end
    chk("drain_first", {pending_write_o, drain_done_o}, 2'b01);
    drain_req_i = 0;
    bus_awready_i = 0;
    store(1, 32'hBFD0_0020, 32'h77, 4'hF, 2'd2);
    chk("ureq_before_rst", bus_awvalid_o, 1);
    rst_n = 0;
    tick();
    reset_vals("reset_mid_ureq");
    rst_n = 1;
    tick();
    for (int c = 0; c < 1500; c++) begin
      we_valid_i = 1'($urandom_range(0, 1));
      uncached_i = $urandom_range(0, 3) == 0;
      paddr_i = 32'h1000 + 32'($urandom_range(0, 31));
      chk_paddr_i = 32'h1000 + 32'($urandom_range(0, 31));
      wdata_i = $urandom;
      strobe_i = 4'($urandom);
      size_i = 2'($urandom);
      we_sel_i = 4'b1 << $urandom_range(0, 3);
      ram_ready_i = 1'($urandom_range(0, 1));
      bus_awready_i = 1'($urandom_range(0, 1));
      bus_bvalid_i = $urandom_range(0, 2) == 0;
      drain_req_i = 1'($urandom_range(0, 1));
      tick();
    end
    we_valid_i = 0; drain_req_i = 0;
    ram_ready_i = 1; bus_awready_i = 1; bus_bvalid_i = 1;
    wait_idle();
    chk("model_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
